// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALUOp and ALUControl codes, and the per-state Moore control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StBranchNe = 4'd12
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluCtlAdd  = 3'b010;
  localparam logic [2:0] AluCtlSub  = 3'b110;
  localparam logic [2:0] AluCtlNone = 3'b000;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    unique case (s)
      StFetch: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      StDecode: c.alusrcb = 2'b11;
      StMemAdr, StAddiEx: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      StMemRead: c.iord = 1'b1;
      StMemWrite: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      StMemWb: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      StExecute: begin
        c.alusrca = 1'b1;
        c.aluop   = AluOpFunct;
      end
      StAluWb: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      StAddiWb: c.regwrite = 1'b1;
      StBranch, StBranchNe: begin
        c.alusrca = 1'b1;
        c.aluop   = AluOpSub;
        c.pcsrc   = 2'b01;
      end
      StJump: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master: controller side (drives selects/enables, reads Op/Funct/Zero)
//   slave:  datapath side
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, State
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
//   aluop_i      : 00 add, 01 sub, 10 use funct, 11 none
//   funct_i      : R-type function field
//   alucontrol_o : 010 add, 110 sub, 000 none
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = AluCtlNone;
    unique case (aluop_i)
      AluOpAdd: alucontrol_o = AluCtlAdd;
      AluOpSub: alucontrol_o = AluCtlSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: alucontrol_o = AluCtlAdd;
          FunctSub: alucontrol_o = AluCtlSub;
          default:  alucontrol_o = AluCtlNone;
        endcase
      end
      default: alucontrol_o = AluCtlNone;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller (Moore FSM) with ALU decoder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, forces FETCH
//   dp    : multicycle_ctrl_if.master -- Op/Funct/Zero in, datapath controls out
// Optional: define MULTICYCLE_CTRL_BNE_EN to decode bne (Op 000101) into BRANCHNE;
// otherwise bne is treated as illegal and returns to FETCH from DECODE.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master dp
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [2:0] alucontrol;

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (dp.Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OpBne:      state_d = StBranchNe;
`endif
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (dp.Op == OpLw) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // Control word is registered alongside the state so outputs are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ctrl_q  <= state_ctrl(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  alu_decoder u_alu_decoder (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (dp.Funct),
    .alucontrol_o (alucontrol)
  );

  // Write enables are masked by rst_n so the FETCH word held in reset is inert,
  // yet becomes live the moment reset releases (the first fetch is not lost).
  assign dp.IorD       = ctrl_q.iord;
  assign dp.IRWrite    = ctrl_q.irwrite & rst_n;
  assign dp.MemWrite   = ctrl_q.memwrite & rst_n;
  assign dp.RegDst     = ctrl_q.regdst;
  assign dp.MemtoReg   = ctrl_q.memtoreg;
  assign dp.RegWrite   = ctrl_q.regwrite & rst_n;
  assign dp.ALUSrcA    = ctrl_q.alusrca;
  assign dp.ALUSrcB    = ctrl_q.alusrcb;
  assign dp.PCSrc      = ctrl_q.pcsrc;
  assign dp.ALUControl = alucontrol;
  assign dp.State      = state_q;
  assign dp.PCEn       = rst_n & (ctrl_q.pcwrite |
                                  ((state_q == StBranch)   &  dp.Zero) |
                                  ((state_q == StBranchNe) & ~dp.Zero));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output
// word for every cycle; a monitor pops and compares at each falling clock edge
// (and on the falling edge of rst_n, to observe the asynchronous reset).
module tb_multicycle_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if dp_if ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp_if)
  );

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // {IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,PCEn,ALUControl,State}
  function automatic logic [18:0] expv(int st, logic z, logic [5:0] fn, bit rl);
    logic iord, irw, mw, rd, m2r, rw, asa, pcen;
    logic [1:0] asb, pcs;
    logic [2:0] ctl;
    {iord, irw, mw, rd, m2r, rw, asa, pcen} = '0;
    asb = 2'b00;
    pcs = 2'b00;
    ctl = 3'b010;
    case (st)
      0:  begin irw = 1; pcen = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
            asa = 1;
            ctl = (fn == 6'b100000) ? 3'b010 : (fn == 6'b100010) ? 3'b110 : 3'b000;
          end
      7:  begin rd = 1; rw = 1; end
      10: rw = 1;
      8:  begin asa = 1; pcs = 2'b01; ctl = 3'b110; pcen = z; end
      12: begin asa = 1; pcs = 2'b01; ctl = 3'b110; pcen = ~z; end
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    if (rl) begin
      irw = 0; mw = 0; rw = 0; pcen = 0;
    end
    return {iord, irw, mw, rd, m2r, rw, asa, asb, pcs, pcen, ctl, st[3:0]};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    logic [18:0] act;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {dp_if.IorD, dp_if.IRWrite, dp_if.MemWrite, dp_if.RegDst, dp_if.MemtoReg,
               dp_if.RegWrite, dp_if.ALUSrcA, dp_if.ALUSrcB, dp_if.PCSrc, dp_if.PCEn,
               dp_if.ALUControl, dp_if.State};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: got %05h expected %05h (state got %0d expected %0d)",
                   e.name, act, e.v, act[3:0], e.v[3:0]);
        end
      end
    end
  end

  task automatic push(input string name, input int st, input bit rl);
    exp_t e;
    e.name = name;
    e.v    = expv(st, dp_if.Zero, dp_if.Funct, rl);
    q.push_back(e);
  endtask

  // Called at posedge+1: record expectation for the current cycle, then advance.
  task automatic step(input string name, input int st);
    push(name, st, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n,
                           input int s0, input int s1, input int s2, input int s3,
                           input int s4);
    int seq[5];
    seq = '{s0, s1, s2, s3, s4};
    dp_if.Op    = op;
    dp_if.Funct = fn;
    dp_if.Zero  = z;
    for (int k = 0; k < n; k++) step($sformatf("%s_s%0d", name, k), seq[k]);
  endtask

  // Assert reset at negedge+3 (clk low, no rising edge involved), release after next posedge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #3;
    push(name, 0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    dp_if.Op    = 6'b111111;
    dp_if.Funct = 6'b000000;
    dp_if.Zero  = 1'b0;
    #1;
    push("reset_init", 0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("lw",      6'b100011, 6'b000000, 1'b0, 5, 0, 1, 2, 3, 4);
    run_instr("sw",      6'b101011, 6'b000000, 1'b0, 4, 0, 1, 2, 5, 0);
    run_instr("sub",     6'b000000, 6'b100010, 1'b0, 4, 0, 1, 6, 7, 0);
    run_instr("or_none", 6'b000000, 6'b100101, 1'b0, 4, 0, 1, 6, 7, 0);
    run_instr("add",     6'b000000, 6'b100000, 1'b1, 4, 0, 1, 6, 7, 0);
    run_instr("addi",    6'b001000, 6'b000000, 1'b0, 4, 0, 1, 9, 10, 0);
    run_instr("beq_tk",  6'b000100, 6'b000000, 1'b1, 3, 0, 1, 8, 0, 0);
    run_instr("beq_nt",  6'b000100, 6'b000000, 1'b0, 3, 0, 1, 8, 0, 0);
`ifdef MULTICYCLE_CTRL_BNE_EN
    run_instr("bne_tk",  6'b000101, 6'b000000, 1'b0, 3, 0, 1, 12, 0, 0);
    run_instr("bne_nt",  6'b000101, 6'b000000, 1'b1, 3, 0, 1, 12, 0, 0);
`else
    run_instr("bne_ill", 6'b000101, 6'b000000, 1'b0, 2, 0, 1, 0, 0, 0);
`endif
    run_instr("j",       6'b000010, 6'b000000, 1'b0, 3, 0, 1, 11, 0, 0);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 2, 0, 1, 0, 0, 0);

    // Reset in the middle of an R-type EXECUTE, then resume from FETCH.
    run_instr("rst_pre", 6'b000000, 6'b100010, 1'b0, 2, 0, 1, 0, 0, 0);
    push("rst_exec", 6, 1'b0);
    async_reset("rst_mid_exec");
    step("rst_fetch", 0);
    step("rst_decode", 1);
    step("rst_exec2", 6);
    step("rst_aluwb", 7);
    step("final_fetch", 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
